// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR owner and fetch sequencer for the control unit.
// The unit walks IDLE -> FETCH -> DECODE -> EXEC -> FETCH ... and reads words
// from instruction memory with a req/ack handshake. It redirects the PC on
// jump or on a taken branch.
// Optional feature macro: IFU_TIMEOUT_EN. When it is defined, a FETCH that
// waits too long for mem_ack raises a sticky fetch_err and parks in HALT.
module instr_fetch_unit #(
  parameter int INSTR_W = 20,
  parameter int ADDR_W  = 10,
  parameter int OFF_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  pc,
  output logic               instr_valid,
  output logic               ir_we,
  output logic               pc_we,
  input  logic               exec_done,
  input  logic               jump,
  input  logic               branch_taken,
  output logic               fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_mem_req;
  logic                r_pc_we;
  logic                w_ack;
  logic                w_ld_ir;
  logic                w_ld_pc;
  logic                w_timeout_hit;
  logic [ADDR_W-1:0]   w_pc_next;

  // Next PC after the current instruction retires. Jump has priority over a
  // taken branch. The offset is sign-extended to the address width, so the
  // sum wraps modulo 2^ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] next_pc(
    input logic [ADDR_W-1:0]  cur_pc,
    input logic [INSTR_W-1:0] cur_ir,
    input logic               do_jump,
    input logic               do_branch
  );
    logic signed [ADDR_W-1:0] off_sext;
    off_sext = signed'({{(ADDR_W-OFF_W){cur_ir[OFF_W-1]}}, cur_ir[OFF_W-1:0]});
    if (do_jump)
      next_pc = cur_ir[ADDR_W-1:0];
    else if (do_branch)
      next_pc = cur_pc + ADDR_W'(1) + ADDR_W'(off_sext);
    else
      next_pc = cur_pc + ADDR_W'(1);
  endfunction

  // An ack only counts while a request is actually outstanding.
  assign w_ack     = r_mem_req && mem_ack;
  assign w_pc_next = next_pc(r_pc, r_ir, jump, branch_taken);

  // Next-state and strobe decode for the fetch sequencer.
  always_comb begin
    w_next  = r_state;
    w_ld_ir = 1'b0;
    w_ld_pc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (w_ack) begin
          w_ld_ir = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout_hit) begin
          w_next = S_HALT;
        end
      end
      S_DECODE: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          w_ld_pc = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, PC, IR and registered strobes. mem_req is registered off the next
  // state, so it rises in the first FETCH cycle together with the new PC.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_mem_req <= 1'b0;
      r_pc_we   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mem_req <= (w_next == S_FETCH);
      r_pc_we   <= w_ld_pc;
      if (w_ld_ir) r_ir <= mem_rdata;
      if (w_ld_pc) r_pc <= w_pc_next;
    end
  end

`ifdef IFU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_fetch_err;

  // The last permitted wait cycle is the one the counter enters at
  // TIMEOUT-1. An ack in that cycle still wins over the timeout.
  assign w_timeout_hit = (r_state == S_FETCH) && !w_ack &&
                         (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  // Wait-cycle counter (cleared on entry to FETCH) and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (r_state != S_FETCH)
        r_wait_cnt <= '0;
      else if (!w_ack)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_timeout_hit) r_fetch_err <= 1'b1;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_timeout_hit = 1'b0;
  assign fetch_err     = 1'b0;
`endif

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign ir          = r_ir;
  assign opcode      = r_ir[INSTR_W-1 -: 4];
  assign instr_valid = (r_state == S_DECODE);
  assign ir_we       = w_ld_ir && !reset;
  assign pc_we       = r_pc_we;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit (default parameters).
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [19:0] mem_rdata = '0;
  logic [19:0] ir;
  logic [3:0]  opcode;
  logic [9:0]  pc;
  logic        instr_valid;
  logic        ir_we;
  logic        pc_we;
  logic        exec_done = 1'b0;
  logic        jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit dut (
    .clock(clock), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .opcode(opcode), .pc(pc), .instr_valid(instr_valid),
    .ir_we(ir_we), .pc_we(pc_we), .exec_done(exec_done), .jump(jump),
    .branch_taken(branch_taken), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  // One clock; inputs are then changed 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From the first FETCH cycle: zero-wait ack, then advance through DECODE into EXEC.
  task automatic load_word(input logic [19:0] w);
    mem_ack = 1'b1; mem_rdata = w;
    step();
    mem_ack = 1'b0;
    step();
  endtask

  // In EXEC: retire with the given decisions; lands in the next FETCH cycle.
  task automatic retire(input logic j, input logic b);
    exec_done = 1'b1; jump = j; branch_taken = b;
    step();
    exec_done = 1'b0; jump = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    total++; if (pc !== 10'h000) begin bad++; $display("FAIL rst_pc got=%h exp=000", pc); end
    total++; if (ir !== 20'h00000) begin bad++; $display("FAIL rst_ir got=%h exp=00000", ir); end
    total++; if ({instr_valid, ir_we, pc_we, fetch_err} !== 4'b0000) begin
      bad++; $display("FAIL rst_strobes got=%b exp=0000", {instr_valid, ir_we, pc_we, fetch_err}); end
    step();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_no_start got=%b exp=0", mem_req); end
  endtask

  task automatic test_basic();
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if ({mem_req, mem_addr} !== {1'b1, 10'h000}) begin
      bad++; $display("FAIL basic_req got=%b/%h exp=1/000", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 20'h01234;
    #1;
    total++; if (ir_we !== 1'b1) begin bad++; $display("FAIL basic_ir_we got=%b exp=1", ir_we); end
    step();
    mem_ack = 1'b0;
    total++; if (ir !== 20'h01234 || opcode !== 4'h0) begin
      bad++; $display("FAIL basic_ir got=%h/%h exp=01234/0", ir, opcode); end
    total++; if ({instr_valid, ir_we, mem_req} !== 3'b100) begin
      bad++; $display("FAIL basic_decode got=%b exp=100", {instr_valid, ir_we, mem_req}); end
    step();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_pulse got=%b exp=0", instr_valid); end
    retire(1'b0, 1'b0);
    total++; if ({pc_we, mem_req, pc, mem_addr} !== {1'b1, 1'b1, 10'h001, 10'h001}) begin
      bad++; $display("FAIL basic_next got=%b%b/%h/%h exp=11/001/001", pc_we, mem_req, pc, mem_addr); end
    step();
    total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL basic_pc_we_pulse got=%b exp=0", pc_we); end
  endtask

  task automatic test_jump();
    mem_ack = 1'b1; mem_rdata = 20'h80005;
    step(); mem_ack = 1'b0; step();
    retire(1'b1, 1'b0);
    total++; if (pc !== 10'h005) begin bad++; $display("FAIL jump_to5 got=%h exp=005", pc); end
    load_word(20'h80123);
    total++; if (opcode !== 4'h8) begin bad++; $display("FAIL jump_opcode got=%h exp=8", opcode); end
    retire(1'b1, 1'b0);
    total++; if ({pc, mem_addr, pc_we} !== {10'h123, 10'h123, 1'b1}) begin
      bad++; $display("FAIL jump_pc got=%h/%h/%b exp=123/123/1", pc, mem_addr, pc_we); end
    load_word(20'h80005);
    retire(1'b1, 1'b0);
    load_word(20'h80123);
    retire(1'b1, 1'b1);
    total++; if (pc !== 10'h123) begin bad++; $display("FAIL jump_over_branch got=%h exp=123", pc); end
  endtask

  task automatic test_branch();
    load_word(20'h80010);
    retire(1'b1, 1'b0);
    load_word(20'h000FC);
    retire(1'b0, 1'b1);
    total++; if (pc !== 10'h00D) begin bad++; $display("FAIL branch_neg got=%h exp=00D", pc); end
    load_word(20'h000FC);
    retire(1'b0, 1'b0);
    total++; if (pc !== 10'h00E) begin bad++; $display("FAIL branch_not_taken got=%h exp=00E", pc); end
    load_word(20'h803FF);
    retire(1'b1, 1'b0);
    load_word(20'h00002);
    retire(1'b0, 1'b1);
    total++; if ({pc, mem_addr} !== {10'h002, 10'h002}) begin
      bad++; $display("FAIL branch_wrap got=%h/%h exp=002/002", pc, mem_addr); end
  endtask

  task automatic test_wait_states();
    exec_done = 1'b1; jump = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if ({mem_req, mem_addr, ir_we, pc_we} !== {1'b1, 10'h002, 1'b0, k == 0}) begin
        bad++; $display("FAIL wait_hold%0d got=%b/%h/%b%b", k, mem_req, mem_addr, ir_we, pc_we); end
      step();
    end
    mem_ack = 1'b1; mem_rdata = 20'h5ABCD;
    #1;
    total++; if ({mem_req, mem_addr, ir_we, ir} !== {1'b1, 10'h002, 1'b1, 20'h00002}) begin
      bad++; $display("FAIL wait_ack got=%b/%h/%b/%h exp=1/002/1/00002", mem_req, mem_addr, ir_we, ir); end
    step();
    mem_ack = 1'b0; exec_done = 1'b0; jump = 1'b0;
    total++; if ({ir, pc, instr_valid} !== {20'h5ABCD, 10'h002, 1'b1}) begin
      bad++; $display("FAIL wait_load got=%h/%h/%b exp=5ABCD/002/1", ir, pc, instr_valid); end
    step();
    mem_ack = 1'b1; mem_rdata = 20'h11111;
    step();
    total++; if ({ir, mem_req, ir_we, instr_valid} !== {20'h5ABCD, 3'b000}) begin
      bad++; $display("FAIL stray_ack got=%h/%b%b%b exp=5ABCD/000", ir, mem_req, ir_we, instr_valid); end
    mem_ack = 1'b0;
    retire(1'b0, 1'b0);
    total++; if (pc !== 10'h003) begin bad++; $display("FAIL wait_retire got=%h exp=003", pc); end
  endtask

  task automatic test_reset_mid_fetch();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if ({mem_req, pc, ir} !== {1'b0, 10'h000, 20'h00000}) begin
      bad++; $display("FAIL midrst got=%b/%h/%h exp=0/000/00000", mem_req, pc, ir); end
    mem_ack = 1'b1; mem_rdata = 20'h7FFFF;
    #1;
    total++; if (ir_we !== 1'b0) begin bad++; $display("FAIL midrst_ir_we got=%b exp=0", ir_we); end
    step();
    mem_ack = 1'b0;
    total++; if ({ir, instr_valid, mem_req} !== {20'h00000, 2'b00}) begin
      bad++; $display("FAIL midrst_late_ack got=%h/%b%b exp=00000/00", ir, instr_valid, mem_req); end
  endtask

  task automatic test_timeout();
    start = 1'b1; step(); start = 1'b0;
`ifdef IFU_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      total++; if (mem_req !== 1'b1 || fetch_err !== 1'b0) begin
        bad++; $display("FAIL to_wait%0d got=%b/%b exp=1/0", k, mem_req, fetch_err); end
      step();
    end
    total++; if ({fetch_err, mem_req} !== 2'b10) begin
      bad++; $display("FAIL to_err got=%b%b exp=10", fetch_err, mem_req); end
    start = 1'b1; step(); step(); start = 1'b0;
    total++; if ({fetch_err, mem_req} !== 2'b10) begin
      bad++; $display("FAIL to_halt got=%b%b exp=10", fetch_err, mem_req); end
    reset = 1'b1; step(); reset = 1'b0;
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", fetch_err); end
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 14; k++) step();
    mem_ack = 1'b1; mem_rdata = 20'h3CAFE;
    #1;
    total++; if ({mem_req, ir_we} !== 2'b11) begin
      bad++; $display("FAIL to_last_ack got=%b%b exp=11", mem_req, ir_we); end
    step();
    mem_ack = 1'b0;
    total++; if ({ir, instr_valid, fetch_err} !== {20'h3CAFE, 2'b10}) begin
      bad++; $display("FAIL to_last_load got=%h/%b%b exp=3CAFE/10", ir, instr_valid, fetch_err); end
`else
    for (int k = 0; k < 20; k++) step();
    total++; if ({mem_req, mem_addr, fetch_err} !== {1'b1, 10'h000, 1'b0}) begin
      bad++; $display("FAIL nto_wait got=%b/%h/%b exp=1/000/0", mem_req, mem_addr, fetch_err); end
    mem_ack = 1'b1; mem_rdata = 20'h3CAFE;
    step();
    mem_ack = 1'b0;
    total++; if ({ir, instr_valid} !== {20'h3CAFE, 1'b1}) begin
      bad++; $display("FAIL nto_load got=%h/%b exp=3CAFE/1", ir, instr_valid); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jump();
    test_branch();
    test_wait_states();
    test_reset_mid_fetch();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
